id_ex_pipe_reg: RTL and testbench

// - Parametrised ID->EX pipeline register with valid/ready handshake, stall backpressure and flush (bubble insert).
// - Sits between decode/register-read and the ALU stage; carries PC, reg indices, operands, immediate, funct and WB/M/EX control.
// - Control fields are zeroed whenever the stage holds no valid entry, so EX/MEM/WB never act on a bubble.

---
 rtl/id_ex_pipe_reg_if.sv | 36 +++
 rtl/id_ex_pipe_reg.sv | 72 +++++++
 tb/tb_id_ex_pipe_reg.sv | 135 +++++++++++++
 3 files changed

// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if: ID->EX handshake, flush and payload bundle.
// master is the decode/EX environment, slave is the pipeline register.
interface id_ex_pipe_reg_if #(
    parameter int XLEN    = 64,
    parameter int REG_AW  = 5,
    parameter int FUNCT_W = 4,
    parameter int WB_W    = 2,
    parameter int M_W     = 3,
    parameter int EX_W    = 3
);
    logic               in_valid, in_ready, flush, out_valid, out_ready;
    logic [XLEN-1:0]    pc, rs1_data, rs2_data, imm;
    logic [REG_AW-1:0]  rs1, rs2, rd;
    logic [FUNCT_W-1:0] funct;
    logic [WB_W-1:0]    wb;
    logic [M_W-1:0]     m;
    logic [EX_W-1:0]    ex;
    logic [XLEN-1:0]    pc_out, rs1_data_out, rs2_data_out, imm_out;
    logic [REG_AW-1:0]  rs1_out, rs2_out, rd_out;
    logic [FUNCT_W-1:0] funct_out;
    logic [WB_W-1:0]    wb_out;
    logic [M_W-1:0]     m_out;
    logic [EX_W-1:0]    ex_out;
    logic [1:0]         alu_op;
    logic               alu_src;
    modport master (
        output in_valid, flush, out_ready, pc, rs1_data, rs2_data, imm, rs1, rs2, rd, funct, wb, m, ex,
        input  in_ready, out_valid, pc_out, rs1_data_out, rs2_data_out, imm_out, rs1_out, rs2_out, rd_out,
               funct_out, wb_out, m_out, ex_out, alu_op, alu_src
    );
    modport slave (
        input  in_valid, flush, out_ready, pc, rs1_data, rs2_data, imm, rs1, rs2, rd, funct, wb, m, ex,
        output in_ready, out_valid, pc_out, rs1_data_out, rs2_data_out, imm_out, rs1_out, rs2_out, rd_out,
               funct_out, wb_out, m_out, ex_out, alu_op, alu_src
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID->EX pipeline register with valid/ready, flush-to-bubble and control zeroing.
// Define ID_EX_SKID_EN to add a skid entry that removes the out_ready->in_ready path.
module id_ex_pipe_reg #(
    parameter int XLEN    = 64,
    parameter int REG_AW  = 5,
    parameter int FUNCT_W = 4,
    parameter int WB_W    = 2,
    parameter int M_W     = 3,
    parameter int EX_W    = 3
) (
    input logic             clk,
    input logic             reset,
    id_ex_pipe_reg_if.slave bus
);
    localparam int DW = 4 * XLEN + 3 * REG_AW + FUNCT_W;
    localparam int CW = WB_W + M_W + EX_W;
    logic          r_live, r_out_valid;
    logic [DW-1:0] r_data, w_in_data, w_src_data;
    logic [CW-1:0] r_ctrl, w_in_ctrl, w_src_ctrl;
    logic          w_push, w_pop, w_src_valid;
    assign w_in_data = {bus.pc, bus.rs1_data, bus.rs2_data, bus.imm, bus.rs1, bus.rs2, bus.rd, bus.funct};
    assign w_in_ctrl = {bus.wb, bus.m, bus.ex};
    assign w_push    = bus.in_valid & bus.in_ready;
    assign w_pop     = r_out_valid & bus.out_ready;
`ifdef ID_EX_SKID_EN
    logic          r_skid_valid;
    logic [DW-1:0] r_skid_data;
    logic [CW-1:0] r_skid_ctrl;
    assign bus.in_ready = r_live & ~r_skid_valid & ~bus.flush;
    always_ff @(posedge clk) begin
        if (reset | bus.flush) begin
            r_skid_valid <= 1'b0;
        end else if (w_push & r_out_valid & ~w_pop) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= w_in_data;
            r_skid_ctrl  <= w_in_ctrl;
        end else if (w_pop) begin
            r_skid_valid <= 1'b0;
        end
    end
    // The skid entry is older than anything arriving, so it refills the output first.
    assign w_src_valid = r_skid_valid | w_push;
    assign w_src_data  = r_skid_valid ? r_skid_data : w_in_data;
    assign w_src_ctrl  = r_skid_valid ? r_skid_ctrl : w_in_ctrl;
`else
    assign bus.in_ready = r_live & ~bus.flush & (~r_out_valid | bus.out_ready);
    assign w_src_valid  = w_push;
    assign w_src_data   = w_in_data;
    assign w_src_ctrl   = w_in_ctrl;
`endif
    always_ff @(posedge clk) begin
        r_live <= ~reset;
        if (reset) begin
            r_out_valid <= 1'b0;
            r_data      <= '0;
            r_ctrl      <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
            r_ctrl      <= '0;
        end else if (~r_out_valid | w_pop) begin
            r_out_valid <= w_src_valid;
            r_ctrl      <= w_src_valid ? w_src_ctrl : '0;
            if (w_src_valid) r_data <= w_src_data;
        end
    end
    assign {bus.pc_out, bus.rs1_data_out, bus.rs2_data_out, bus.imm_out,
            bus.rs1_out, bus.rs2_out, bus.rd_out, bus.funct_out} = r_data;
    assign {bus.wb_out, bus.m_out, bus.ex_out} = r_ctrl;
    assign bus.out_valid = r_out_valid;
    assign bus.alu_op    = r_ctrl[1:0];
    assign bus.alu_src   = r_ctrl[EX_W-1];
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed + random stimulus against a FIFO-queue model of the ID->EX stage.
module tb_id_ex_pipe_reg;
    localparam int XLEN = 64, REG_AW = 5, FUNCT_W = 4, WB_W = 2, M_W = 3, EX_W = 3;
    localparam int CMP_W = 320;
    typedef struct packed {
        logic [XLEN-1:0]    pc, rs1_data, rs2_data, imm;
        logic [REG_AW-1:0]  rs1, rs2, rd;
        logic [FUNCT_W-1:0] funct;
        logic [WB_W-1:0]    wb;
        logic [M_W-1:0]     m;
        logic [EX_W-1:0]    ex;
    } entry_t;
    logic   clk = 1'b0;
    logic   reset = 1'b1;
    int     n_checks = 0;
    int     n_fail = 0;
    entry_t exp_q[$];
    entry_t last = '0;
    logic   live = 1'b0;
    entry_t m_act, m_exp, m_in;
    logic   m_rdy;
    entry_t e;
    id_ex_pipe_reg_if #(.XLEN(XLEN), .REG_AW(REG_AW), .FUNCT_W(FUNCT_W), .WB_W(WB_W), .M_W(M_W), .EX_W(EX_W)) bus ();
    id_ex_pipe_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .FUNCT_W(FUNCT_W), .WB_W(WB_W), .M_W(M_W), .EX_W(EX_W)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [CMP_W-1:0] act, input logic [CMP_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask
    function automatic entry_t mk(input logic [XLEN-1:0] pc);
        entry_t r;
        r.pc       = pc;
        r.rs1_data = {$urandom, $urandom};
        r.rs2_data = {$urandom, $urandom};
        r.imm      = {$urandom, $urandom};
        r.rs1      = REG_AW'($urandom);
        r.rs2      = REG_AW'($urandom);
        r.rd       = REG_AW'($urandom);
        r.funct    = FUNCT_W'($urandom);
        r.wb       = WB_W'($urandom);
        r.m        = M_W'($urandom);
        r.ex       = EX_W'($urandom);
        return r;
    endfunction
    task automatic drive(input logic v, input entry_t d, input logic f, input logic ordy);
        bus.in_valid  = v;
        bus.flush     = f;
        bus.out_ready = ordy;
        {bus.pc, bus.rs1_data, bus.rs2_data, bus.imm, bus.rs1, bus.rs2, bus.rd, bus.funct, bus.wb, bus.m, bus.ex} = d;
        @(posedge clk);
        #1;
    endtask
    // Monitor/scoreboard: check state after the last rising edge, then advance the model across the next one.
    always @(negedge clk) begin
        m_act = {bus.pc_out, bus.rs1_data_out, bus.rs2_data_out, bus.imm_out, bus.rs1_out, bus.rs2_out,
                 bus.rd_out, bus.funct_out, bus.wb_out, bus.m_out, bus.ex_out};
`ifdef ID_EX_SKID_EN
        m_rdy = live & ~bus.flush & (exp_q.size() < 2);
`else
        m_rdy = live & ~bus.flush & ((exp_q.size() == 0) | bus.out_ready);
`endif
        chk("out_valid", CMP_W'(bus.out_valid), CMP_W'(exp_q.size() != 0));
        chk("in_ready", CMP_W'(bus.in_ready), CMP_W'(m_rdy));
        if (exp_q.size() != 0) begin
            m_exp = exp_q[0];
            last  = m_exp;
        end else begin
            m_exp    = last;
            m_exp.wb = '0;
            m_exp.m  = '0;
            m_exp.ex = '0;
        end
        chk("payload", CMP_W'(m_act), CMP_W'(m_exp));
        chk("alu_op", CMP_W'(bus.alu_op), CMP_W'(m_exp.ex[1:0]));
        chk("alu_src", CMP_W'(bus.alu_src), CMP_W'(m_exp.ex[EX_W-1]));
        m_in = {bus.pc, bus.rs1_data, bus.rs2_data, bus.imm, bus.rs1, bus.rs2, bus.rd, bus.funct, bus.wb, bus.m, bus.ex};
        if (reset) begin
            exp_q.delete();
            live = 1'b0;
            last = '0;
        end else if (bus.flush) begin
            exp_q.delete();
            live = 1'b1;
        end else begin
            if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
            if (bus.in_valid && m_rdy) exp_q.push_back(m_in);
            live = 1'b1;
        end
    end
    initial begin
        reset = 1'b1;
        drive(1'b1, mk(64'h10), 1'b0, 1'b1);
        drive(1'b1, mk(64'h14), 1'b0, 1'b1);
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, mk(64'h100 + 64'(4 * i)), 1'b0, 1'b1);
        repeat (2) drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b1, mk(64'h200), 1'b0, 1'b0);
        e = mk(64'h204);
        repeat (3) drive(1'b1, e, 1'b0, 1'b0);
        repeat (3) drive(1'b0, '0, 1'b0, 1'b1);
        e = mk(64'h300);
        e.wb = 2'b11;
        e.m  = 3'b101;
        drive(1'b1, e, 1'b0, 1'b0);
        drive(1'b1, mk(64'h304), 1'b1, 1'b0);
        repeat (2) drive(1'b0, '0, 1'b0, 1'b1);
        e = mk(64'h400);
        e.ex = 3'b110;
        drive(1'b1, e, 1'b0, 1'b0);
        repeat (2) drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b1, mk(64'h500), 1'b0, 1'b0);
        drive(1'b1, mk(64'h504), 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) drive(1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (3) drive(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 2) != 0, mk({$urandom, $urandom}), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) != 0);
        end
        reset = 1'b0;
        repeat (4) drive(1'b0, '0, 1'b0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
